// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared state encoding and opcode constants for the
// instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT      = 3'd2,
    S_IMM_FETCH = 3'd3,
    S_IMM_WAIT  = 3'd4,
    S_EXEC      = 3'd5,
    S_HALTED    = 3'd6
  } state_t;

  // Opcode field lives in the low nibble of every instruction word
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 3;

  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_HALT = 4'b1111;

endpackage

// File: rtl/fetch_seq_wdog.sv
// fetch_seq_wdog: cycle counter that raises expire on the MAX_STEPS-th
// enabled cycle after a clear.
module fetch_seq_wdog #(
  parameter int MAX_STEPS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(MAX_STEPS + 1);

  logic [CW-1:0] count;

  // Count enabled cycles since the last clear, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == CW'(MAX_STEPS - 1));

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer between a synchronous instruction
// memory and the multi-cycle processor (DIN/Run/Done handshake).
// Optional EXEC watchdog: define FETCH_SEQ_WATCHDOG_EN.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int START_ADDR = 0,
  parameter int MAX_STEPS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              halt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] imm;
  logic              first_exec;
  logic              halt_req;
  logic              wdog_expire;
  logic [3:0]        mem_op;
  logic [3:0]        ir_op;

  assign mem_op = mem_data[OPC_MSB:OPC_LSB];
  assign ir_op  = ir[OPC_MSB:OPC_LSB];

`ifdef FETCH_SEQ_WATCHDOG_EN
  logic fault_q;

  fetch_seq_wdog #(
    .MAX_STEPS(MAX_STEPS)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != S_EXEC),
    .enable(state == S_EXEC),
    .expire(wdog_expire)
  );

  // Sticky fault: set on a watchdog timeout, cleared when Go resumes from HALTED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (state == S_EXEC && !done && wdog_expire) begin
      fault_q <= 1'b1;
    end else if (state == S_HALTED && go) begin
      fault_q <= 1'b0;
    end
  end

  assign fault = fault_q;
`else
  assign wdog_expire = 1'b0;
  assign fault       = 1'b0;
`endif

  // Main sequencer: walks fetch, optional immediate fetch and execute, owns PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= START_PC;
      ir         <= '0;
      imm        <= '0;
      first_exec <= 1'b0;
      halt_req   <= 1'b0;
    end else begin
      if (halt && state != S_IDLE && state != S_HALTED) begin
        halt_req <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (go) state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          ir <= mem_data;
          pc <= pc + 1'b1;
          if (mem_op == OP_HALT) begin
            state    <= S_HALTED;
            halt_req <= 1'b0;
          end else if (mem_op == OP_MVI) begin
            state <= S_IMM_FETCH;
          end else begin
            state      <= S_EXEC;
            first_exec <= 1'b1;
          end
        end
        S_IMM_FETCH: begin
          state <= S_IMM_WAIT;
        end
        S_IMM_WAIT: begin
          imm        <= mem_data;
          pc         <= pc + 1'b1;
          state      <= S_EXEC;
          first_exec <= 1'b1;
        end
        S_EXEC: begin
          first_exec <= 1'b0;
          if (done) begin
            if (halt || halt_req) begin
              state    <= S_HALTED;
              halt_req <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end else if (wdog_expire) begin
            state    <= S_HALTED;
            halt_req <= 1'b0;
          end
        end
        S_HALTED: begin
          if (go) state <= S_FETCH;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en = (state == S_FETCH) || (state == S_IMM_FETCH);
  assign mem_addr  = pc;
  assign run       = (state == S_EXEC);
  assign busy      = (state != S_IDLE) && (state != S_HALTED);
  assign din       = (state != S_EXEC)                  ? '0 :
                     (first_exec || ir_op != OP_MVI)    ? ir : imm;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: self-checking bench for fetch_seq with a synchronous memory
// model, a scripted processor model and an instruction-level reference.
module tb_fetch_seq;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int MAX_STEPS = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              go = 1'b0;
  logic              halt = 1'b0;
  logic              done = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] din;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fault;

  logic [DATA_W-1:0] mem [256];
  logic [ADDR_W-1:0] pcModel;
  int                testCount = 0;
  int                failCount = 0;

  fetch_seq #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .START_ADDR(0),
    .MAX_STEPS (MAX_STEPS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .halt     (halt),
    .mem_addr (mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_data (mem_data),
    .din      (din),
    .run      (run),
    .done     (done),
    .pc       (pc),
    .busy     (busy),
    .fault    (fault)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    go    = 1'b0;
    halt  = 1'b0;
    done  = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    pcModel = '0;
  endtask

  task automatic goPulse();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_run"}, run, 0);
    checkOutput({tag, "_rd_en"}, mem_rd_en, 0);
    checkOutput({tag, "_din"}, din, 0);
    checkOutput({tag, "_pc"}, pc, pcModel);
    checkOutput({tag, "_fault"}, fault, 0);
  endtask

  // One instruction from its FETCH cycle to the boundary. execLen is the EXEC
  // cycle on which the processor raises Done. haltMode: 0 none, 1 Halt held
  // during EXEC from cycle 2 and on the Done cycle, 2 Halt pulsed in FETCH.
  task automatic applyStimulus(input int execLen, input int haltMode,
                               input bit noise, output bit halted);
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] expDin;
    bit                isMvi;
    word   = mem[pcModel];
    imm    = '0;
    isMvi  = (word[3:0] == 4'h1);
    halted = 1'b0;

    checkOutput("fetch_rd_en", mem_rd_en, 1);
    checkOutput("fetch_addr", mem_addr, pcModel);
    checkOutput("fetch_run", run, 0);
    checkOutput("fetch_busy", busy, 1);
    if (noise) begin
      go   = 1'($urandom_range(0, 1));
      done = 1'($urandom_range(0, 1));
    end
    if (haltMode == 2) halt = 1'b1;
    step();
    go = 1'b0; done = 1'b0; halt = 1'b0;

    checkOutput("wait_rd_en", mem_rd_en, 0);
    checkOutput("wait_din", din, 0);
    pcModel = pcModel + 1'b1;
    if (noise) begin
      go   = 1'($urandom_range(0, 1));
      done = 1'($urandom_range(0, 1));
    end
    step();
    go = 1'b0; done = 1'b0;

    if (word[3:0] == 4'hF) begin
      halted = 1'b1;
      checkOutput("haltop_busy", busy, 0);
      checkOutput("haltop_run", run, 0);
      checkOutput("haltop_pc", pc, pcModel);
      checkOutput("haltop_rd_en", mem_rd_en, 0);
      return;
    end

    if (isMvi) begin
      imm = mem[pcModel];
      checkOutput("imm_rd_en", mem_rd_en, 1);
      checkOutput("imm_addr", mem_addr, pcModel);
      checkOutput("imm_run", run, 0);
      if (noise) done = 1'($urandom_range(0, 1));
      step();
      done = 1'b0;
      checkOutput("immwait_rd_en", mem_rd_en, 0);
      pcModel = pcModel + 1'b1;
      step();
    end

    for (int k = 1; k <= execLen; k++) begin
      expDin = (k == 1 || !isMvi) ? word : imm;
      checkOutput("exec_run", run, 1);
      checkOutput("exec_busy", busy, 1);
      checkOutput("exec_din", din, expDin);
      checkOutput("exec_pc", pc, pcModel);
      checkOutput("exec_rd_en", mem_rd_en, 0);
      if (haltMode == 1 && (k >= 2 || k == execLen)) halt = 1'b1;
      if (k == execLen) done = 1'b1;
      else if (noise) go = 1'($urandom_range(0, 1));
      step();
      go = 1'b0; done = 1'b0; halt = 1'b0;
    end

    if (haltMode != 0) begin
      halted = 1'b1;
      checkOutput("halted_busy", busy, 0);
      checkOutput("halted_run", run, 0);
      checkOutput("halted_pc", pc, pcModel);
    end
  endtask

  initial begin
    bit h;
    logic [DATA_W-1:0] w;
    int r;

    // Reset state
    resetDut();
    checkIdle("reset");
    checkOutput("reset_addr", mem_addr, 0);

    // mv followed by a halt word
    mem[0] = 16'h0000;
    mem[1] = 16'hFFFF;
    goPulse();
    applyStimulus(2, 0, 1'b0, h);
    applyStimulus(2, 0, 1'b0, h);
    checkIdle("mv_halt");
    checkOutput("mv_halt_pc", pc, 2);

    // mvi with immediate
    resetDut();
    mem[0] = 16'h0001;
    mem[1] = 16'h1234;
    mem[2] = 16'hFFFF;
    goPulse();
    applyStimulus(3, 0, 1'b0, h);
    applyStimulus(2, 0, 1'b0, h);
    checkIdle("mvi_halt");

    // Halt during a 4-cycle add, then resume at PC=1
    resetDut();
    mem[0] = 16'h0002;
    mem[1] = 16'h0000;
    mem[2] = 16'hFFFF;
    goPulse();
    applyStimulus(4, 1, 1'b0, h);
    checkIdle("halt_add");
    goPulse();
    checkOutput("resume_addr", mem_addr, 1);
    applyStimulus(2, 0, 1'b0, h);
    applyStimulus(2, 0, 1'b0, h);
    checkIdle("resume_halt");

    // Reset in the 2nd EXEC cycle
    resetDut();
    mem[0] = 16'h0002;
    mem[1] = 16'hFFFF;
    goPulse();
    step();
    step();
    checkOutput("rst_exec1_run", run, 1);
    step();
    checkOutput("rst_exec2_run", run, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_run", run, 0);
    checkOutput("rst_async_pc", pc, 0);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_addr", mem_addr, 0);
    #2;
    rst_n = 1'b1;
    pcModel = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_idle_rd_en", mem_rd_en, 0);
      checkOutput("rst_idle_busy", busy, 0);
    end
    goPulse();
    applyStimulus(2, 0, 1'b0, h);
    applyStimulus(2, 0, 1'b0, h);
    checkIdle("rst_resume");

    // Watchdog behaviour on an instruction whose Done never comes
    resetDut();
    mem[0] = 16'h0002;
    mem[1] = 16'h0000;
    mem[2] = 16'hFFFF;
    goPulse();
    step();
    step();
`ifdef FETCH_SEQ_WATCHDOG_EN
    for (int k = 1; k <= MAX_STEPS; k++) begin
      checkOutput("wdog_run", run, 1);
      checkOutput("wdog_fault_pre", fault, 0);
      step();
    end
    checkOutput("wdog_fault", fault, 1);
    checkOutput("wdog_run_off", run, 0);
    checkOutput("wdog_busy", busy, 0);
    checkOutput("wdog_pc", pc, 1);
    goPulse();
    checkOutput("wdog_fault_clr", fault, 0);
    pcModel = 1;
    applyStimulus(2, 0, 1'b0, h);
    applyStimulus(2, 0, 1'b0, h);
    checkIdle("wdog_end");
`else
    for (int k = 1; k <= MAX_STEPS + 4; k++) begin
      checkOutput("nowdog_run", run, 1);
      checkOutput("nowdog_fault", fault, 0);
      step();
    end
    done = 1'b1;
    step();
    done = 1'b0;
    pcModel = 1;
    applyStimulus(2, 0, 1'b0, h);
    applyStimulus(2, 0, 1'b0, h);
    checkIdle("nowdog_end");
`endif

    // Randomized programs long enough for the PC to wrap past 255
    resetDut();
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      r = $urandom_range(0, 15);
      if (r == 0)      w[3:0] = 4'hF;
      else if (r <= 4) w[3:0] = 4'h1;
      else             w[3:0] = 4'($urandom_range(2, 14));
      mem[i] = w;
    end
    goPulse();
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(1, 5),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0,
                    1'b1, h);
      if (h) begin
        checkIdle("rand_halted");
        goPulse();
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
